// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;
    localparam int DIV_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;
endpackage

// File: rtl/div_row.sv
// One restoring-division row: shift in a dividend bit, trial-subtract the divisor, restore on borrow.
module div_row
    import div_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] dvs_i,
    output logic         borrow_o,
    output logic [W-1:0] rem_o
);
    logic [W:0]   shifted;
    logic [W+1:0] diff;
    logic         unused_msb;

    assign shifted  = {rem_i, bit_i};
    assign diff     = {1'b0, shifted} - {2'b00, dvs_i};
    assign borrow_o = diff[W+1];
    // Whichever value is selected is below the divisor, so its top bit is always zero.
    assign rem_o      = borrow_o ? shifted[W-1:0] : diff[W-1:0];
    assign unused_msb = ^{shifted[W], diff[W]};
endmodule

// File: rtl/div_seq.sv
// Sequential W-cycle restoring divider, signed or unsigned, with valid/ready handshakes on both sides.
module div_seq
    import div_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         signed_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] quotient_o,
    output logic [W-1:0] remainder_o,
    output logic         dbz_o
);
    localparam int CW = $clog2(W);

    div_state_t    state_reg;
    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  dvd_reg;
    logic [W-1:0]  dvs_reg;
    logic [W-1:0]  rem_reg;
    logic          sgn_reg;
    logic          dvd_neg_reg;
    logic          dvs_neg_reg;
    logic          zero_reg;
    logic [W-1:0]  quotient_reg;
    logic [W-1:0]  remainder_reg;
    logic          dbz_reg;

    logic          borrow;
    logic [W-1:0]  row_rem;
    logic [W-1:0]  dvd_mag;
    logic [W-1:0]  dvs_mag;
    logic [W-1:0]  q_next;
    logic [W-1:0]  q_fix;
    logic [W-1:0]  r_fix;

    assign dvd_mag = (signed_i && dividend_i[W-1]) ? -dividend_i : dividend_i;
    assign dvs_mag = (signed_i && divisor_i[W-1])  ? -divisor_i  : divisor_i;

    div_row #(.W(W)) u_row (
        .rem_i    (rem_reg),
        .bit_i    (dvd_reg[W-1]),
        .dvs_i    (dvs_reg),
        .borrow_o (borrow),
        .rem_o    (row_rem)
    );

    // The dividend register doubles as the quotient shift register.
    assign q_next = {dvd_reg[W-2:0], ~borrow};

    // A zero divisor never borrows, so the remainder already holds the dividend magnitude
    // and the sign fix below turns it back into the raw dividend.
    always_comb begin
        q_fix = q_next;
        if (zero_reg)
            q_fix = '1;
        else if (sgn_reg && (dvd_neg_reg ^ dvs_neg_reg))
            q_fix = -q_next;
        r_fix = (sgn_reg && dvd_neg_reg) ? -row_rem : row_rem;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            dvd_reg       <= '0;
            dvs_reg       <= '0;
            rem_reg       <= '0;
            sgn_reg       <= 1'b0;
            dvd_neg_reg   <= 1'b0;
            dvs_neg_reg   <= 1'b0;
            zero_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid_i) begin
                        state_reg   <= RUN;
                        cnt_reg     <= CW'(W - 1);
                        dvd_reg     <= dvd_mag;
                        dvs_reg     <= dvs_mag;
                        rem_reg     <= '0;
                        sgn_reg     <= signed_i;
                        dvd_neg_reg <= dividend_i[W-1];
                        dvs_neg_reg <= divisor_i[W-1];
                        zero_reg    <= (divisor_i == '0);
                    end
                end
                RUN: begin
                    dvd_reg <= q_next;
                    rem_reg <= row_rem;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        state_reg     <= DONE;
                        cnt_reg       <= '0;
                        quotient_reg  <= q_fix;
                        remainder_reg <= r_fix;
                        dbz_reg       <= zero_reg;
                    end
                end
                DONE: begin
                    if (out_ready_i)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_reg == IDLE);
    assign out_valid_o = (state_reg == DONE);
    assign quotient_o  = quotient_reg;
    assign remainder_o = remainder_reg;
    assign dbz_o       = dbz_reg;
endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq at W=8.
module tb_div_seq;
    localparam int W = 8;

    typedef struct packed {
        logic       s;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         signed_in = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    div_seq #(.W(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .signed_i    (signed_in),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .dbz_o       (dbz)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, scramble the operand inputs after the accept edge,
    // and count edges until out_valid rises (bounded).
    task automatic do_op(input logic s, input logic [7:0] a, input logic [7:0] b, output int lat);
        in_valid  = 1'b1;
        signed_in = s;
        dividend  = a;
        divisor   = b;
        tick();
        in_valid  = 1'b0;
        signed_in = ~s;
        dividend  = 8'hA5;
        divisor   = 8'h3C;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({out_valid, quotient, remainder, dbz} !== {1'b0, 8'h00, 8'h00, 1'b0}) begin
            n_fails++;
            $display("FAIL reset_outputs: got v=%b q=%h r=%h z=%b, expected all zero",
                     out_valid, quotient, remainder, dbz);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_ready: got in_ready=%b expected 1", in_ready);
        end
        $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
    endtask

    task automatic test_arith();
        vec_t v[8];
        int   lat;
        v = '{'{1'b0, 8'd200, 8'd7,  8'd28,  8'd4,  1'b0},
              '{1'b0, 8'hF9,  8'h02, 8'h7C,  8'h01, 1'b0},
              '{1'b0, 8'hFF,  8'hFF, 8'h01,  8'h00, 1'b0},
              '{1'b0, 8'h05,  8'h09, 8'h00,  8'h05, 1'b0},
              '{1'b1, 8'hF9,  8'h02, 8'hFD,  8'hFF, 1'b0},
              '{1'b1, 8'h07,  8'hFE, 8'hFD,  8'h01, 1'b0},
              '{1'b1, 8'hF9,  8'hFE, 8'h03,  8'hFF, 1'b0},
              '{1'b1, 8'h80,  8'hFF, 8'h80,  8'h00, 1'b0}};
        for (int i = 0; i < 8; i++) begin
            do_op(v[i].s, v[i].a, v[i].b, lat);
            $display("arith %0d: s=%b %h/%h -> q=%h r=%h z=%b lat=%0d",
                     i, v[i].s, v[i].a, v[i].b, quotient, remainder, dbz, lat);
            n_checks++;
            if (lat !== 8) begin
                n_fails++;
                $display("FAIL arith%0d_latency: got %0d edges expected 8", i, lat);
            end
            n_checks++;
            if ({out_valid, quotient, remainder, dbz} !== {1'b1, v[i].q, v[i].r, v[i].z}) begin
                n_fails++;
                $display("FAIL arith%0d_result: got v=%b q=%h r=%h z=%b expected v=1 q=%h r=%h z=%b",
                         i, out_valid, quotient, remainder, dbz, v[i].q, v[i].r, v[i].z);
            end
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fails++;
                $display("FAIL arith%0d_busy: got in_ready=%b expected 0", i, in_ready);
            end
            tick();
            n_checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_fails++;
                $display("FAIL arith%0d_release: got v=%b rdy=%b expected v=0 rdy=1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_dbz();
        vec_t v[3];
        int   lat;
        v = '{'{1'b0, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b1},
              '{1'b1, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b1},
              '{1'b1, 8'hF0, 8'h00, 8'hFF, 8'hF0, 1'b1}};
        for (int i = 0; i < 3; i++) begin
            do_op(v[i].s, v[i].a, v[i].b, lat);
            $display("dbz %0d: s=%b %h/%h -> q=%h r=%h z=%b lat=%0d",
                     i, v[i].s, v[i].a, v[i].b, quotient, remainder, dbz, lat);
            n_checks++;
            if (lat !== 8) begin
                n_fails++;
                $display("FAIL dbz%0d_latency: got %0d edges expected 8", i, lat);
            end
            n_checks++;
            if ({out_valid, quotient, remainder, dbz} !== {1'b1, v[i].q, v[i].r, v[i].z}) begin
                n_fails++;
                $display("FAIL dbz%0d_result: got v=%b q=%h r=%h z=%b expected v=1 q=%h r=%h z=%b",
                         i, out_valid, quotient, remainder, dbz, v[i].q, v[i].r, v[i].z);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        do_op(1'b0, 8'd200, 8'd7, lat);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({out_valid, in_ready, quotient, remainder, dbz} !== {1'b1, 1'b0, 8'd28, 8'd4, 1'b0}) begin
                n_fails++;
                $display("FAIL hold%0d: got v=%b rdy=%b q=%h r=%h z=%b expected v=1 rdy=0 q=1c r=04 z=0",
                         k, out_valid, in_ready, quotient, remainder, dbz);
            end
            in_valid = 1'b1;
            dividend = 8'h11;
            divisor  = 8'h00;
            tick();
            in_valid = 1'b0;
        end
        n_checks++;
        if ({out_valid, quotient, remainder} !== {1'b1, 8'd28, 8'd4}) begin
            n_fails++;
            $display("FAIL hold_end: got v=%b q=%h r=%h expected v=1 q=1c r=04", out_valid, quotient, remainder);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fails++;
            $display("FAIL hold_release: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
        end
        tick();
        n_checks++;
        if ({out_valid, in_ready, quotient, remainder} !== {1'b0, 1'b1, 8'd28, 8'd4}) begin
            n_fails++;
            $display("FAIL hold_idle: got v=%b rdy=%b q=%h r=%h expected v=0 rdy=1 q=1c r=04",
                     out_valid, in_ready, quotient, remainder);
        end
        $display("backpressure: released, in_ready=%b", in_ready);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen;
        in_valid  = 1'b1;
        signed_in = 1'b0;
        dividend  = 8'd100;
        divisor   = 8'd3;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({in_ready, out_valid, quotient, remainder, dbz} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
            n_fails++;
            $display("FAIL midrun_reset: got rdy=%b v=%b q=%h r=%h z=%b expected rdy=1 v=0 q=00 r=00 z=0",
                     in_ready, out_valid, quotient, remainder, dbz);
        end
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fails++;
            $display("FAIL midrun_stray_valid: got %0d valid cycles expected 0", seen);
        end
        do_op(1'b0, 8'd100, 8'd3, lat);
        $display("midrun retry: 64/03 -> q=%h r=%h lat=%0d", quotient, remainder, lat);
        n_checks++;
        if ({lat == 8, out_valid, quotient, remainder, dbz} !== {1'b1, 1'b1, 8'd33, 8'd1, 1'b0}) begin
            n_fails++;
            $display("FAIL midrun_retry: got lat=%0d v=%b q=%h r=%h z=%b expected lat=8 v=1 q=21 r=01 z=0",
                     lat, out_valid, quotient, remainder, dbz);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_dbz();
        test_backpressure();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter W, default 8: operand, quotient and remainder width; legal range 4..32.
REQ-002 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 in_valid_i  input  1  operand request valid.
REQ-005 in_ready_o  output  1  block can accept an operand request.
REQ-006 signed_i  input  1  1 = two's-complement operation, 0 = unsigned; sampled with the operands.
REQ-007 dividend_i  input  W  dividend.
REQ-008 divisor_i  input  W  divisor.
REQ-009 out_valid_o  output  1  result valid.
REQ-010 out_ready_i  input  1  consumer accepts the result.
REQ-011 quotient_o  output  W  quotient.
REQ-012 remainder_o  output  W  remainder.
REQ-013 dbz_o  output  1  divide-by-zero flag, qualified by out_valid_o.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE; in_ready_o = (state==IDLE); out_valid_o = (state==DONE).
REQ-015 IDLE->RUN SHALL occur on in_valid_i & in_ready_o; the edge SHALL latch the operand magnitudes, signed_i, both sign bits and a zero-divisor flag, clear the partial remainder, and load the bit counter with W-1.
REQ-016 Operand magnitudes SHALL be the two's-complement negation when signed_i=1 and the operand MSB=1; otherwise the raw value.
REQ-017 Each RUN cycle SHALL perform one restoring row: shift the next dividend MSB into the partial remainder, compute a (W+1)-bit subtraction of the divisor magnitude, and set the quotient bit = ~borrow; on borrow, keep the shifted remainder (restore); otherwise take the difference.
REQ-018 RUN->DONE SHALL occur on the cycle with counter==0; out_valid_o SHALL therefore rise exactly W clock edges after the accept edge.
REQ-019 Sign correction SHALL be applied on the RUN->DONE edge: quotient negated when signed and the operand signs differ; remainder negated when signed and the dividend is negative (truncation toward zero).
REQ-020 Signed overflow (most-negative / -1) SHALL yield quotient = most-negative and remainder 0, with no flag.
REQ-021 Divisor 0 SHALL yield quotient all ones, remainder = the raw dividend, and dbz_o=1, with the same W-cycle latency, regardless of signed_i.
REQ-022 DONE->IDLE SHALL occur on out_ready_i=1; the outputs SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-023 in_valid_i SHALL be ignored outside IDLE; operand inputs SHALL be don't-care after the accept edge.
REQ-024 quotient_o, remainder_o and dbz_o SHALL be registered and SHALL change only on the RUN->DONE edge or on reset.

Reset
REQ-025 rst_i=1 SHALL force IDLE, the counter to 0, and quotient_o, remainder_o, dbz_o and out_valid_o to 0 on the next edge.
REQ-026 Reset SHALL take priority over every transition, including mid-RUN and DONE; any in-flight operation SHALL be discarded without producing a result.
REQ-027 in_ready_o SHALL be 1 on the first cycle after rst_i deasserts.

Structure
REQ-028 Package div_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and the default-width constant.
REQ-029 One combinational sub-module, div_row, SHALL be parametrised by W and implement a single restoring row: (W+1)-bit partial remainder, divisor, borrow out, and output select between the difference and the restored value.
REQ-030 div_seq SHALL instantiate div_row exactly once and reuse it across the iterations.

Verification (W=8)
REQ-031 Unsigned 200/7 -> out_valid_o 8 edges after accept; quotient 28, remainder 4, dbz 0.
REQ-032 Signed -7/2 (0xF9/0x02) -> quotient 0xFD, remainder 0xFF.
REQ-033 0x55/0x00, either mode -> quotient 0xFF, remainder 0x55, dbz 1, same 8-cycle latency.
REQ-034 Signed 0x80/0xFF -> quotient 0x80, remainder 0x00.
REQ-035 out_ready_i held low 5 cycles in DONE -> outputs stable, in_ready_o 0, in_valid_i pulses ignored; ready high -> IDLE next edge.
REQ-036 rst_i asserted on the 3rd RUN cycle -> next edge IDLE, all outputs 0, no out_valid_o pulse; a new request then completes correctly.
